// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster-timing bundle between the timing generator and its consumers.
//
// Signals:
//   pix_ce      pixel clock enable into the generator
//   x, y        active-area coordinates (0 outside the active area)
//   hsync       horizontal sync
//   vsync       vertical sync
//   de          data enable, high inside the active area
//   line_start  one-clk strobe on entering h=0
//   frame_start one-clk strobe on entering (h,v)=(0,0)
//
// Modports:
//   master  the timing generator (consumes pix_ce, drives timing)
//   slave   a consumer such as the renderer / connector (drives pix_ce)
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          pix_ce;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pix_ce,
        output x, y, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  x, y, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// Walks a horizontal counter h (0..H_TOTAL-1) and vertical counter v (0..V_TOTAL-1), one
// step per clk with pix_ce high, and produces registered syncs, data enable, coordinates and
// line/frame strobes aligned with the counter position just entered.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    vga_timing_gen_if.master: pix_ce in; x, y, hsync, vsync, de, line_start,
//          frame_start out
//
// Build option:
//   VGA_TIMING_SCALE_EN  when defined, x/y are h/v right-shifted by SCALE_SHIFT during de
//                        (coarse pong grid); otherwise full pixel coordinates.
module vga_timing_gen #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          H_POL       = 1'b0,
    parameter bit          V_POL       = 1'b0,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 10
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT      = 16'(H_RES);
    localparam logic [15:0] V_ACT      = 16'(V_RES);
    localparam logic [15:0] HS_FIRST   = 16'(H_RES + H_FP);
    localparam logic [15:0] HS_LAST    = 16'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST   = 16'(V_RES + V_FP);
    localparam logic [15:0] VS_LAST    = 16'(V_RES + V_FP + V_SYNC - 1);

`ifdef VGA_TIMING_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif
    localparam int unsigned SHIFT = SCALE_EN ? SCALE_SHIFT : 0;

    // Raster counters
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;

    // Registered outputs
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Next counter position; holds when pix_ce is low.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (bus.pix_ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
            end else begin
                h_d = h_q + 16'd1;
            end
        end
    end

    // Outputs are decoded from the next position so they line up with the counters after
    // the edge. Levels hold naturally with pix_ce low because h_d/v_d hold; strobes are
    // gated by pix_ce so they drop on the following clk regardless of the enable.
    always_comb begin
        de_d          = (h_d < H_ACT) && (v_d < V_ACT);
        x_d           = de_d ? XW'(h_d >> SHIFT) : '0;
        y_d           = de_d ? YW'(v_d >> SHIFT) : '0;
        hsync_d       = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? H_POL : ~H_POL;
        vsync_d       = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? V_POL : ~V_POL;
        line_start_d  = bus.pix_ce && (h_d == '0);
        frame_start_d = bus.pix_ce && (h_d == '0) && (v_d == '0);
    end

    // Reset parks the counters on the last position so the first enabled edge enters (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 sync block.
- Adds configurable resolution, porches, sync polarity and a pixel clock-enable in place of an internal clock divider.
- Adds a data-enable output, line and frame start strobes, and an asynchronous active-low reset.
- Feeds the pong renderer with pixel coordinates and drives the VGA connector syncs.

Parameters:
H_RES, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_RES, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
SCALE_SHIFT, 2, coordinate right-shift; used only with VGA_TIMING_SCALE_EN
XW, 10, width of x output; must hold H_RES-1
YW, 10, width of y output; must hold V_RES-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel clock enable; one pixel per clk with pix_ce=1
x  out  XW  active-area column, 0 outside active area
y  out  YW  active-area row, 0 outside active area
hsync  out  1  horizontal sync, polarity H_POL
vsync  out  1  vertical sync, polarity V_POL
de  out  1  1 while (h,v) is inside the active area
line_start  out  1  single-clk pulse when h becomes 0
frame_start  out  1  single-clk pulse when (h,v) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
- Internal counters: h in 0..H_TOTAL-1, v in 0..V_TOTAL-1, each 16 bits wide.
- Reset (rst_n low, asynchronous):
  - counters go to h=H_TOTAL-1, v=V_TOTAL-1;
  - x=0, y=0, de=0, line_start=0, frame_start=0;
  - hsync=~H_POL, vsync=~V_POL (inactive).
- Advance only on rising clk with pix_ce=1.
  - h wraps to 0 after H_TOTAL-1.
  - v increments only when h wraps, and wraps to 0 after V_TOTAL-1.
- With pix_ce=0, counters and all level outputs hold.
- Every output is a register loaded from the next-state counter values. Outputs are therefore aligned with the counter position just entered (zero extra latency); no combinational output paths.
- de = (h < H_RES) && (v < V_RES).
- x = h and y = v when de=1, else both 0.
- hsync active exactly for h in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1], i.e. H_SYNC pixels per line.
- vsync active exactly for v in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1]. Because it is a function of v, it toggles only on the edge where h wraps to 0.
- line_start = 1 for one clk on each ce edge entering h=0, blanking lines included: V_TOTAL pulses per frame.
- frame_start = 1 for one clk on the ce edge entering (0,0); it coincides with a line_start pulse.
- Strobes clear on the next clk edge regardless of pix_ce.
- First pix_ce after reset release lands on (0,0): frame_start=1, line_start=1, de=1.
- Reset asserted mid-frame: outputs take reset values immediately; the frame restarts cleanly at the first pix_ce after release.

Optional Feature:
Macro: VGA_TIMING_SCALE_EN
- Defined: x = h>>SCALE_SHIFT and y = v>>SCALE_SHIFT during de (coarse pong grid); 0 outside de. Port widths unchanged, upper bits zero.
- Undefined: x, y are full pixel coordinates; SCALE_SHIFT is ignored.

Test Plan:
- Defaults, pix_ce=1, release reset -> frame_start at first edge; next frame_start exactly 420000 clks later; 525 line_start pulses per frame.
- Defaults, one line -> de high for 640 clks; hsync low from h=656 through h=751 (exactly 96 clks), high elsewhere; x counts 0..639, then 0.
- Defaults, one frame -> 307200 de cycles total; vsync low exactly during lines 490-491 (1600 clks); y=479 on the last active line, 0 after.
- pix_ce pulsed 1-in-4 -> counters and levels change only on ce edges; strobes last exactly 1 clk; frame period 1680000 clks.
- H_POL=1, V_POL=1, H_RES=800, H_FP=40, H_SYNC=128, H_BP=88, V_RES=600, V_FP=1, V_SYNC=4, V_BP=23 -> hsync high for h 840..967; vsync high for v 601..604; H_TOTAL 1056, V_TOTAL 628.
- rst_n pulsed low at h=300, v=200 -> outputs are reset values within the same cycle; first ce after release gives x=0, y=0, de=1, frame_start=1.
- VGA_TIMING_SCALE_EN defined, SCALE_SHIFT=2 -> at h=639, v=479: x=159, y=119; at h=3, v=5: x=0, y=1.
